// File: rtl/seq_mult_reconstruct.sv
// Sequential shift-and-add multiplier with addend, P = A*B + C, one multiplier bit per clock.
// Optional EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all zero.
module seq_mult_reconstruct #(
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rset,
   input  logic               start,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   input  logic [WIDTH-1:0]   C,
   output logic               ready,
   output logic               done,
   output logic [2*WIDTH-1:0] P
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIN
   } state_t;

   state_t             state;
   logic [2*WIDTH-1:0] a_sh;
   logic [WIDTH-1:0]   b_sh;
   logic [2*WIDTH-1:0] acc;
   logic [CW-1:0]      cnt;
   logic               last;

   // last is evaluated on pre-shift values, so it flags the iteration now executing
   always_comb begin
      last = (cnt == LAST);
`ifdef EARLY_TERM_EN
      if (b_sh[WIDTH-1:1] == '0)
         last = 1'b1;
`endif
   end

   always_ff @(posedge clk) begin
      if (rset) begin
         state <= IDLE;
         a_sh  <= '0;
         b_sh  <= '0;
         acc   <= '0;
         cnt   <= '0;
         P     <= '0;
         done  <= 1'b0;
         ready <= 1'b1;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh  <= {{WIDTH{1'b0}}, A};
                  b_sh  <= B;
                  acc   <= {{WIDTH{1'b0}}, C};
                  cnt   <= '0;
                  ready <= 1'b0;
                  state <= RUN;
               end
            end
            RUN: begin
               if (b_sh[0])
                  acc <= acc + a_sh;
               a_sh <= a_sh << 1;
               b_sh <= b_sh >> 1;
               cnt  <= cnt + 1'b1;
               if (last)
                  state <= FIN;
            end
            FIN: begin
               P     <= acc;
               done  <= 1'b1;
               ready <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_mult_reconstruct.sv
// Directed bench for seq_mult_reconstruct (WIDTH=16); expected latency follows EARLY_TERM_EN.
module tb_seq_mult_reconstruct;

   logic        clk = 1'b0;
   logic        rset = 1'b1;
   logic        start = 1'b0;
   logic [15:0] A = '0;
   logic [15:0] B = '0;
   logic [15:0] C = '0;
   logic        ready;
   logic        done;
   logic [31:0] P;

   int n_checks = 0;
   int n_pass   = 0;

   seq_mult_reconstruct #(.WIDTH(16)) dut (
      .clk   (clk),
      .rset  (rset),
      .start (start),
      .A     (A),
      .B     (B),
      .C     (C),
      .ready (ready),
      .done  (done),
      .P     (P)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // edges from accepting edge to done edge
   function automatic int exp_lat(input logic [15:0] b);
`ifdef EARLY_TERM_EN
      int m;
      m = 0;
      for (int i = 0; i < 16; i++)
         if (b[i]) m = i + 1;
      return 1 + ((m < 1) ? 1 : m);
`else
      return 17;
`endif
   endfunction

   task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [31:0] exp);
      int lat;
      bit rdy_bad;
      A = a; B = b; C = c; start = 1'b1;
      tick();
      start = 1'b0;
      lat = 0;
      rdy_bad = 1'b0;
      while (!done && lat < 40) begin
         if (ready) rdy_bad = 1'b1;
         tick();
         lat++;
      end
      check({tag, "_lat"}, lat, exp_lat(b));
      check({tag, "_busy"}, rdy_bad, 1'b0);
      check({tag, "_P"}, P, exp);
      check({tag, "_rdy"}, ready, 1'b1);
      tick();
      check({tag, "_pulse"}, done, 1'b0);
   endtask

   initial begin
      int ndone;

      // reset held for two cycles
      tick();
      tick();
      rset = 1'b0;
      check("rst_P", P, 32'd0);
      check("rst_done", done, 1'b0);
      check("rst_ready", ready, 1'b1);
      tick();
      check("idle_ready", ready, 1'b1);

      // main function
      run_op("div100", 16'd7, 16'd14, 16'd2, 32'd100);
      run_op("max", 16'hFFFF, 16'hFFFF, 16'hFFFF, 32'hFFFF0000);
      run_op("b0", 16'd5, 16'd0, 16'd9, 32'd9);
      run_op("a0", 16'd0, 16'd123, 16'd77, 32'd77);
      run_op("b1", 16'd9, 16'd1, 16'd0, 32'd9);
      run_op("mix", 16'd1234, 16'd56, 16'd789, 32'd69893);

      // start while busy is ignored
      A = 16'd7; B = 16'd14; C = 16'd2; start = 1'b1;
      tick();
      start = 1'b0;
      ndone = 0;
      for (int i = 1; i <= 40; i++) begin
         if (i == 5) begin
            start = 1'b1; A = 16'd2; B = 16'd2; C = 16'd0;
         end
         tick();
         if (i == 5) start = 1'b0;
         if (done) ndone++;
      end
      check("busy_ndone", ndone, 1);
      check("busy_P", P, 32'd100);

      // reset mid-operation aborts it
      A = 16'd1000; B = 16'h8001; C = 16'd5; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         if (i == 8) rset = 1'b1;
         tick();
      end
      rset = 1'b0;
      check("abort_done", done, 1'b0);
      check("abort_P", P, 32'd0);
      check("abort_ready", ready, 1'b1);
      ndone = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (done) ndone++;
      end
      check("abort_ndone", ndone, 0);
      run_op("after_abort", 16'd3, 16'd4, 16'd0, 32'd12);

      // back-to-back: start held through the done cycle
      A = 16'd7; B = 16'd14; C = 16'd2; start = 1'b1;
      tick();
      A = 16'd3; B = 16'd5; C = 16'd1;
      ndone = 0;
      while (!done && ndone < 40) begin
         tick();
         ndone++;
      end
      check("b2b_first_lat", ndone, exp_lat(16'd14));
      check("b2b_first_P", P, 32'd100);
      tick();
      start = 1'b0;
      check("b2b_accept", ready, 1'b0);
      check("b2b_hold_P", P, 32'd100);
      ndone = 0;
      while (!done && ndone < 40) begin
         tick();
         ndone++;
      end
      check("b2b_second_lat", ndone, exp_lat(16'd5));
      check("b2b_second_P", P, 32'd16);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
